// File: rtl/integrate_dump_pkg.sv
// Shared types and helpers for the integrate-and-dump controller.
package integrate_dump_pkg;

  localparam int unsigned N_DEF = 16;  // input sample width
  localparam int unsigned M_DEF = 24;  // accumulator / output width
  localparam int unsigned W_DEF = 8;   // window-length field width

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Two's complement add overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/integrate_dump_acc_core.sv
// Accumulate datapath: wide signed accumulator with sticky overflow.
// sum_o/ovf_sticky_o show the value including the current sample when en_i is high.
module integrate_dump_acc_core
  import integrate_dump_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                ld_zero_i,
  input  logic signed [N-1:0] in_i,
  output logic signed [M-1:0] sum_o,
  output logic                ovf_sticky_o
);

  logic signed [M-1:0] acc_q, acc_d;
  logic signed [M-1:0] ext_c, add_c;
  logic                ovf_q, ovf_d;

  assign ext_c = M'(in_i);
  assign add_c = acc_q + ext_c;

  always_comb begin
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    sum_o        = acc_q;
    ovf_sticky_o = ovf_q;
    if (en_i) begin
      sum_o        = add_c;
      ovf_sticky_o = ovf_q | add_ovf(acc_q[M-1], ext_c[M-1], add_c[M-1]);
    end
    // Dump restarts the next window from zero, dropping any pending add.
    if (ld_zero_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      acc_d = sum_o;
      ovf_d = ovf_sticky_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump controller: sums a window of samples and presents the
// result on a valid/ready output, with early flush and per-window overflow.
module integrate_dump
  import integrate_dump_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic [W-1:0]        len_i,
  input  logic                flush_i,
  input  logic signed [N-1:0] in_i,
  input  logic                in_v_i,
  output logic                in_r_o,
  output logic signed [M-1:0] out_o,
  output logic                out_v_o,
  input  logic                out_r_i,
  output logic                ovf_o,
  output logic                busy_o
);

  generate
    if (M < N) begin : g_width_chk
      $error("integrate_dump: accumulator width M must be >= sample width N");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [W-1:0]        count_q, count_d;
  logic [W-1:0]        len_q, len_d;
  logic [W-1:0]        eff_len_c;
  logic signed [M-1:0] out_q, out_d;
  logic                out_v_q, out_v_d;
  logic                ovf_q, ovf_d;
  logic                accept_c, last_c, dump_c;
  logic signed [M-1:0] sum_c;
  logic                ovf_sticky_c;

  integrate_dump_acc_core #(.N(N), .M(M)) u_acc_core (
    .clk_i        (clk_i),
    .clr_i        (clr_i),
    .en_i         (accept_c),
    .ld_zero_i    (dump_c),
    .in_i         (in_i),
    .sum_o        (sum_c),
    .ovf_sticky_o (ovf_sticky_c)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    out_d     = out_q;
    out_v_d   = out_v_q;
    ovf_d     = ovf_q;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    dump_c    = 1'b0;
    // First sample of a window uses live len; len=0 wraps to a 2^W window below.
    eff_len_c = (count_q == '0) ? len_i : len_q;
    case (state_q)
      ST_ACC: begin
        accept_c = in_v_i;
        last_c   = accept_c && (count_q == eff_len_c - W'(1));
        dump_c   = last_c || (flush_i && (accept_c || (count_q != '0)));
        if (accept_c && (count_q == '0)) len_d = len_i;
        if (dump_c) begin
          out_d   = sum_c;
          ovf_d   = ovf_sticky_c;
          out_v_d = 1'b1;
          count_d = '0;
          state_d = ST_HOLD;
        end else if (accept_c) begin
          count_d = count_q + W'(1);
        end
      end
      ST_HOLD: begin
        if (out_r_i) begin
          out_v_d = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_ACC;
      count_q <= '0;
      len_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_r_o  = (state_q == ST_ACC);
  assign busy_o  = (state_q == ST_HOLD) || (count_q != '0);
  assign out_o   = out_q;
  assign out_v_o = out_v_q;
  assign ovf_o   = ovf_q;

endmodule
